// File: rtl/hazard_if.sv
// Hazard unit bus: pipeline-stage hazard inputs and stall/bypass outputs.
// The slave modport is the hazard unit; the master modport is the pipeline.
interface hazard_if #(
    parameter int REG_AW      = 5,
    parameter int STALL_CNT_W = 16
);
    logic                   IF_Req;
    logic                   IF_Ack;
    logic [REG_AW-1:0]      ID_Rs;
    logic [REG_AW-1:0]      ID_Rt;
    logic                   ID_RsRead;
    logic                   ID_RtRead;
    logic [REG_AW-1:0]      EX_Rw;
    logic                   EX_RegWrite;
    logic                   EX_MemRead;
    logic [REG_AW-1:0]      M_Rw;
    logic                   M_RegWrite;
    logic                   M_MemRead;
    logic                   EX_MulDivStart;
    logic                   M_Stall_Controller;
    logic                   IF_Stall;
    logic                   ID_Stall;
    logic                   EX_Stall;
    logic                   M_Stall;
    logic                   WB_Stall;
    logic [1:0]             ID_FwdRs;
    logic [1:0]             ID_FwdRt;
    logic                   MulDivBusy;
    logic [STALL_CNT_W-1:0] StallCount;

    modport slave (
        input  IF_Req, IF_Ack, ID_Rs, ID_Rt, ID_RsRead, ID_RtRead,
               EX_Rw, EX_RegWrite, EX_MemRead, M_Rw, M_RegWrite, M_MemRead,
               EX_MulDivStart, M_Stall_Controller,
        output IF_Stall, ID_Stall, EX_Stall, M_Stall, WB_Stall,
               ID_FwdRs, ID_FwdRt, MulDivBusy, StallCount
    );

    modport master (
        output IF_Req, IF_Ack, ID_Rs, ID_Rt, ID_RsRead, ID_RtRead,
               EX_Rw, EX_RegWrite, EX_MemRead, M_Rw, M_RegWrite, M_MemRead,
               EX_MulDivStart, M_Stall_Controller,
        input  IF_Stall, ID_Stall, EX_Stall, M_Stall, WB_Stall,
               ID_FwdRs, ID_FwdRt, MulDivBusy, StallCount
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: fetch-wait tracking, mul/div occupancy, RAW hazard
// detection with optional EX/MEM bypass select, stall composition and a
// saturating stall-cycle counter.
// Optional feature macro: HAZARD_FORWARD_EN (bypass non-load matches instead
// of stalling on them).
module hazard_unit #(
    parameter int REG_AW        = 5,
    parameter int MULDIV_CYCLES = 32,
    parameter int STALL_CNT_W   = 16
) (
    input  logic    clock,
    input  logic    reset,
    hazard_if.slave hz
);
    localparam int NUM_OPS = 2;   // operand 0 = Rs, operand 1 = Rt
    localparam int MD_W    = (MULDIV_CYCLES > 2) ? $clog2(MULDIV_CYCLES) : 1;

    typedef enum logic { F_IDLE, F_WAIT } fstate_t;

    fstate_t                          fstate, fstate_nxt;
    logic                             fetch_stall;
    logic [MD_W-1:0]                  md_cnt;
    logic                             md_busy;
    logic                             id_hazard;
    logic [NUM_OPS-1:0][REG_AW-1:0]   src;
    logic [NUM_OPS-1:0]               src_rd;
    logic [NUM_OPS-1:0]               op_haz;
    logic [NUM_OPS-1:0][1:0]          op_fwd;
    logic                             m_stall, ex_stall, id_stall;
    logic [STALL_CNT_W-1:0]           stall_cnt;

    // Fetch FSM state register
    always_ff @(posedge clock) begin
        if (reset) fstate <= F_IDLE;
        else       fstate <= fstate_nxt;
    end

    // Fetch FSM next state; a same-cycle ack never stalls
    always_comb begin
        fstate_nxt  = fstate;
        fetch_stall = 1'b0;
        case (fstate)
            F_IDLE: if (hz.IF_Req && !hz.IF_Ack) begin
                fstate_nxt  = F_WAIT;
                fetch_stall = 1'b1;
            end
            F_WAIT: if (hz.IF_Ack) fstate_nxt  = F_IDLE;
                    else           fetch_stall = 1'b1;
            default: fstate_nxt = F_IDLE;
        endcase
    end

    // Mul/div occupancy: free-running countdown, starts ignored while busy
    always_ff @(posedge clock) begin
        if (reset)                   md_cnt <= '0;
        else if (md_cnt != '0)       md_cnt <= md_cnt - MD_W'(1);
        else if (hz.EX_MulDivStart)  md_cnt <= MD_W'(MULDIV_CYCLES - 1);
    end

    assign md_busy = (md_cnt != '0);

    assign src    = {hz.ID_Rt, hz.ID_Rs};
    assign src_rd = {hz.ID_RtRead, hz.ID_RsRead};

    // Per-operand RAW detection; register 0 never matches, EX beats MEM
    for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
        logic ex_m, mem_m;
        assign ex_m  = src_rd[i] && (src[i] != '0) && (src[i] == hz.EX_Rw) && hz.EX_RegWrite;
        assign mem_m = src_rd[i] && (src[i] != '0) && (src[i] == hz.M_Rw)  && hz.M_RegWrite;
`ifdef HAZARD_FORWARD_EN
        // Only a load in the selected stage cannot be bypassed
        assign op_haz[i] = ex_m ? hz.EX_MemRead : (mem_m && hz.M_MemRead);
        assign op_fwd[i] = (ex_m && !hz.EX_MemRead)           ? 2'b01 :
                           (!ex_m && mem_m && !hz.M_MemRead)  ? 2'b10 : 2'b00;
`else
        assign op_haz[i] = ex_m || mem_m;
        assign op_fwd[i] = 2'b00;
`endif
    end

    assign id_hazard = |op_haz;

    // Stalls flow strictly downstream-to-upstream, so no loop exists
    assign m_stall  = fetch_stall | hz.M_Stall_Controller;
    assign ex_stall = md_busy | m_stall;
    assign id_stall = ex_stall | id_hazard;

    assign hz.M_Stall    = m_stall;
    assign hz.WB_Stall   = m_stall;
    assign hz.EX_Stall   = ex_stall;
    assign hz.ID_Stall   = id_stall;
    assign hz.IF_Stall   = fetch_stall | id_stall;
    assign hz.ID_FwdRs   = op_fwd[0];
    assign hz.ID_FwdRt   = op_fwd[1];
    assign hz.MulDivBusy = md_busy;
    assign hz.StallCount = stall_cnt;

    // Saturating count of ID stall cycles
    always_ff @(posedge clock) begin
        if (reset)                           stall_cnt <= '0;
        else if (id_stall && stall_cnt != '1) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameters SHALL be one per line: name, default, meaning.
- REG_AW, 5, register address width.
- MULDIV_CYCLES, 32, EX multicycle occupancy in cycles (>=2).
- STALL_CNT_W, 16, stall-statistics counter width.
REQ-003 Ports SHALL be one per line: name, direction, width, meaning.
- clock, in, 1, rising-edge clock.
- reset, in, 1, synchronous active-high reset.
- IF_Req, in, 1, instruction fetch request issued.
- IF_Ack, in, 1, instruction memory acknowledge.
- ID_Rs, in, REG_AW, ID source register A.
- ID_Rt, in, REG_AW, ID source register B.
- ID_RsRead, in, 1, ID uses Rs.
- ID_RtRead, in, 1, ID uses Rt.
- EX_Rw, in, REG_AW, EX destination register.
- EX_RegWrite, in, 1, EX writes a register.
- EX_MemRead, in, 1, EX is a load.
- M_Rw, in, REG_AW, MEM destination register.
- M_RegWrite, in, 1, MEM writes a register.
- M_MemRead, in, 1, MEM is a load.
- EX_MulDivStart, in, 1, EX issues a mul/div.
- M_Stall_Controller, in, 1, data-memory controller stall.
- IF_Stall, ID_Stall, EX_Stall, M_Stall, WB_Stall, out, 1 each, per-stage stall.
- ID_FwdRs, out, 2, Rs bypass select: 00 regfile, 01 EX, 10 MEM.
- ID_FwdRt, out, 2, Rt bypass select, same encoding.
- MulDivBusy, out, 1, multicycle unit occupied.
- StallCount, out, STALL_CNT_W, saturating count of ID_Stall cycles.

Function
REQ-004 The fetch FSM SHALL have states F_IDLE and F_WAIT: F_IDLE goes to F_WAIT on IF_Req & !IF_Ack; F_WAIT goes to F_IDLE on IF_Ack; all other cases hold state.
REQ-005 FetchStall SHALL be (F_IDLE & IF_Req & !IF_Ack) | (F_WAIT & !IF_Ack); an ack in the same cycle as the request SHALL cause zero stall cycles.
REQ-006 The mul/div counter SHALL load MULDIV_CYCLES-1 on EX_MulDivStart when it is zero, decrement by one per cycle while nonzero, and ignore EX_MulDivStart while nonzero; MulDivBusy SHALL equal (counter != 0).
REQ-007 The counter SHALL decrement regardless of any stall input.
REQ-008 A match SHALL require: the read enable set, the source register != 0, the source register equal to the stage's Rw, and that stage's RegWrite set; register 0 SHALL never match.
REQ-009 An EX match SHALL take priority over a MEM match for the same operand.
REQ-010 ID_Hazard SHALL be asserted for an operand whose selected match is in a stage with MemRead set (load-use).
REQ-011 Stall composition SHALL be:
- M_Stall = FetchStall | M_Stall_Controller.
- WB_Stall = M_Stall.
- EX_Stall = MulDivBusy | M_Stall.
- ID_Stall = EX_Stall | ID_Hazard.
- IF_Stall = FetchStall | ID_Stall.
- The composition SHALL contain no combinational loop.
REQ-012 StallCount SHALL increment on each cycle with ID_Stall high and SHALL saturate at all-ones without wrapping.
REQ-013 All outputs other than the FSM state, the mul/div counter and StallCount SHALL be combinational from the inputs and the current state.

Reset
REQ-014 While reset is high, the next state SHALL be F_IDLE, the counter 0 and StallCount 0; one cycle after reset, MulDivBusy SHALL be 0 and FetchStall SHALL depend only on IF_Req and IF_Ack.
REQ-015 Reset asserted mid-operation SHALL abort a pending fetch wait or mul/div occupancy within one clock, with no residual stall.

Configuration
REQ-016 With macro HAZARD_FORWARD_EN defined, a non-load match SHALL drive ID_FwdRs/ID_FwdRt to 01 (EX) or 10 (MEM) with no ID_Hazard, and a load match SHALL stall per REQ-010.
REQ-017 Without HAZARD_FORWARD_EN, any match in EX or MEM SHALL assert ID_Hazard, and ID_FwdRs/ID_FwdRt SHALL be constant 00.

Verification
REQ-018 The bench SHALL cover the following directed scenarios:
- IF_Req=1 with IF_Ack arriving 3 cycles later -> IF_Stall and M_Stall high for exactly 3 cycles; same-cycle ack -> 0 stall cycles.
- EX_MulDivStart pulse with MULDIV_CYCLES=32 -> MulDivBusy and EX_Stall high for 31 cycles; a second start at cycle 10 is ignored.
- ID_Rs=5 (read), EX_Rw=5, EX_RegWrite=1, EX_MemRead=0, forward enabled -> ID_FwdRs=01, ID_Stall=0; same with EX_MemRead=1 -> ID_Stall=1; forward disabled -> ID_Stall=1, ID_FwdRs=00.
- ID_Rt=7 matching both EX_Rw=7 and M_Rw=7 -> ID_FwdRt=01; ID_Rs=0 matching EX_Rw=0 -> no hazard.
- STALL_CNT_W=4 with ID_Stall held for 20 cycles -> StallCount=15; reset during a busy mul/div -> MulDivBusy=0 on the next cycle.
